// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- bundle of every handshake/bus signal around the memory stage.
//
//   exe2mem side : head entry of the execute->memory FIFO (RES_RE ...
//                  EXE2MEM_EMPTY_SE) and the pop strobe EXE2MEM_POP_SM.
//   dmem side    : request/acknowledge bus to the data memory
//                  (DMEM_REQ_SM ... DMEM_ACK_SM).
//   mem2wbk side : one-entry output slot seen by writeback/bypass
//                  (MEM_RES_RM ... EXCEPTION_SM) and its pop MEM2WBK_POP_SW.
//
//   modport master : the memory stage itself.
//   modport slave  : the surrounding pipeline / memory / writeback.
// ---------------------------------------------------------------------------
interface mem_stage_if;
    // exe2mem FIFO head
    logic [31:0] RES_RE;
    logic [31:0] MEM_DATA_RE;
    logic [5:0]  DEST_RE;
    logic [1:0]  MEM_SIZE_RE;
    logic        WB_RE;
    logic        MEM_SIGN_EXTEND_RE;
    logic        MEM_LOAD_RE;
    logic        MEM_STORE_RE;
    logic        EXCEPTION_RE;
    logic        CSR_WENABLE_RE;
    logic        MULT_INST_RE;
    logic [31:0] CSR_RDATA_RE;
    logic        EXE2MEM_EMPTY_SE;
    logic        EXE2MEM_POP_SM;
    // data memory
    logic        DMEM_REQ_SM;
    logic        DMEM_WE_SM;
    logic [31:0] DMEM_ADR_SM;
    logic [3:0]  DMEM_BE_SM;
    logic [31:0] DMEM_WDATA_SM;
    logic [31:0] DMEM_RDATA_SM;
    logic        DMEM_ACK_SM;
    // writeback / bypass
    logic        MEM2WBK_POP_SW;
    logic        BP_MEM2WBK_EMPTY_SM;
    logic [31:0] MEM_RES_RM;
    logic [5:0]  MEM_DEST_RM;
    logic        MEM_WB_RM;
    logic        CSR_WENABLE_RM;
    logic [31:0] CSR_RDATA_RM;
    logic        MULT_INST_RM;
    logic        EXCEPTION_SM;

    modport master (
        input  RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE, WB_RE,
               MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, EXCEPTION_RE,
               CSR_WENABLE_RE, MULT_INST_RE, CSR_RDATA_RE, EXE2MEM_EMPTY_SE,
               DMEM_RDATA_SM, DMEM_ACK_SM, MEM2WBK_POP_SW,
        output EXE2MEM_POP_SM, DMEM_REQ_SM, DMEM_WE_SM, DMEM_ADR_SM,
               DMEM_BE_SM, DMEM_WDATA_SM, BP_MEM2WBK_EMPTY_SM, MEM_RES_RM,
               MEM_DEST_RM, MEM_WB_RM, CSR_WENABLE_RM, CSR_RDATA_RM,
               MULT_INST_RM, EXCEPTION_SM
    );

    modport slave (
        output RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE, WB_RE,
               MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, EXCEPTION_RE,
               CSR_WENABLE_RE, MULT_INST_RE, CSR_RDATA_RE, EXE2MEM_EMPTY_SE,
               DMEM_RDATA_SM, DMEM_ACK_SM, MEM2WBK_POP_SW,
        input  EXE2MEM_POP_SM, DMEM_REQ_SM, DMEM_WE_SM, DMEM_ADR_SM,
               DMEM_BE_SM, DMEM_WDATA_SM, BP_MEM2WBK_EMPTY_SM, MEM_RES_RM,
               MEM_DEST_RM, MEM_WB_RM, CSR_WENABLE_RM, CSR_RDATA_RM,
               MULT_INST_RM, EXCEPTION_SM
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory stage of the pipeline.
//
// Takes the head of the exe2mem FIFO. Non-memory (and excepting) entries go
// straight into a one-entry output slot with one cycle of latency. Loads and
// stores first issue a data-memory request that is held stable until
// acknowledged; on the ack the head is popped and the slot written (loads
// carry the aligned/extended read data, stores never write back).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      mem_stage_if.master (exe2mem head, dmem bus, output slot)
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset_n,
    mem_stage_if.master bus
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        head, memop, slot_free;
    logic        pop, slot_wr, issue;
    logic [31:0] wr_res;
    logic        wr_wb, wr_csr_we;

    // data-memory request registers
    logic        req_p0, we_p0;
    logic [31:0] adr_p0, wdata_p0;
    logic [3:0]  be_p0;

    // output slot registers
    logic        vld_p1;
    logic [31:0] res_p1, csr_rdata_p1;
    logic [5:0]  dest_p1;
    logic        wb_p1, csr_we_p1, mult_p1;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   byte_en = 4'b0011 << off;
            2'b10:   byte_en = 4'b0001 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic [1:0] off, input logic sext);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b01:   load_fmt = {{16{sh[15] & sext}}, sh[15:0]};
            2'b10:   load_fmt = {{24{sh[7] & sext}}, sh[7:0]};
            default: load_fmt = sh;
        endcase
    endfunction

    assign head      = !bus.EXE2MEM_EMPTY_SE;
    assign memop     = head && (bus.MEM_LOAD_RE || bus.MEM_STORE_RE) && !bus.EXCEPTION_RE;
    assign slot_free = !vld_p1 || bus.MEM2WBK_POP_SW;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (memop && slot_free) state_nxt = ACCESS;
            ACCESS:  if (bus.DMEM_ACK_SM)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        slot_wr   = 1'b0;
        issue     = 1'b0;
        wr_res    = bus.RES_RE;
        // excepting entries never write a register or a CSR
        wr_wb     = bus.WB_RE && !bus.EXCEPTION_RE;
        wr_csr_we = bus.CSR_WENABLE_RE && !bus.EXCEPTION_RE;
        case (state)
            IDLE: begin
                if (head && slot_free) begin
                    if (memop) begin
                        issue = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        slot_wr = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // the slot was free at issue and nothing else writes it here
                if (bus.DMEM_ACK_SM) begin
                    pop     = 1'b1;
                    slot_wr = 1'b1;
                    if (bus.MEM_STORE_RE) wr_wb = 1'b0;
                    else wr_res = load_fmt(bus.DMEM_RDATA_SM, bus.MEM_SIZE_RE,
                                           adr_p0[1:0], bus.MEM_SIGN_EXTEND_RE);
                end
            end
            default: ;
        endcase
        if (!reset_n) begin
            pop     = 1'b0;
            slot_wr = 1'b0;
            issue   = 1'b0;
        end
    end

    // stage p0: memory request, held until acknowledged
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_p0   <= 1'b0;
            we_p0    <= 1'b0;
            adr_p0   <= '0;
            be_p0    <= '0;
            wdata_p0 <= '0;
        end else if (issue) begin
            req_p0   <= 1'b1;
            we_p0    <= bus.MEM_STORE_RE;
            adr_p0   <= bus.RES_RE;
            be_p0    <= byte_en(bus.MEM_SIZE_RE, bus.RES_RE[1:0]);
            wdata_p0 <= bus.MEM_DATA_RE << {bus.RES_RE[1:0], 3'b000};
        end else if (state == ACCESS && bus.DMEM_ACK_SM) begin
            req_p0   <= 1'b0;
        end
    end

    // stage p1: output slot; a write wins over a simultaneous pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1       <= 1'b0;
            res_p1       <= '0;
            dest_p1      <= '0;
            wb_p1        <= 1'b0;
            csr_we_p1    <= 1'b0;
            csr_rdata_p1 <= '0;
            mult_p1      <= 1'b0;
        end else if (slot_wr) begin
            vld_p1       <= 1'b1;
            res_p1       <= wr_res;
            dest_p1      <= bus.DEST_RE;
            wb_p1        <= wr_wb;
            csr_we_p1    <= wr_csr_we;
            csr_rdata_p1 <= bus.CSR_RDATA_RE;
            mult_p1      <= bus.MULT_INST_RE;
        end else if (bus.MEM2WBK_POP_SW) begin
            vld_p1       <= 1'b0;
        end
    end

    assign bus.EXE2MEM_POP_SM      = pop;
    assign bus.EXCEPTION_SM        = head && bus.EXCEPTION_RE;
    assign bus.DMEM_REQ_SM         = req_p0;
    assign bus.DMEM_WE_SM          = we_p0;
    assign bus.DMEM_ADR_SM         = adr_p0;
    assign bus.DMEM_BE_SM          = be_p0;
    assign bus.DMEM_WDATA_SM       = wdata_p0;
    assign bus.BP_MEM2WBK_EMPTY_SM = !vld_p1;
    assign bus.MEM_RES_RM          = res_p1;
    // an empty slot must never look like a pending register write
    assign bus.MEM_DEST_RM         = vld_p1 ? dest_p1 : 6'd0;
    assign bus.MEM_WB_RM           = vld_p1 && wb_p1;
    assign bus.CSR_WENABLE_RM      = csr_we_p1;
    assign bus.CSR_RDATA_RM        = csr_rdata_p1;
    assign bus.MULT_INST_RM        = mult_p1;
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have exe2mem inputs: RES_RE in 32 (ALU result or address); MEM_DATA_RE in 32 (store data); DEST_RE in 6; MEM_SIZE_RE in 2 (00 word, 01 half, 10 byte); WB_RE, MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, EXCEPTION_RE, CSR_WENABLE_RE, MULT_INST_RE in 1; CSR_RDATA_RE in 32; EXE2MEM_EMPTY_SE in 1.
REQ-004 SHALL have: EXE2MEM_POP_SM  out  1  pops exe2mem head this cycle.
REQ-005 SHALL have data-memory ports: DMEM_REQ_SM out 1; DMEM_WE_SM out 1; DMEM_ADR_SM out 32; DMEM_BE_SM out 4; DMEM_WDATA_SM out 32; DMEM_RDATA_SM in 32; DMEM_ACK_SM in 1.
REQ-006 SHALL have writeback/bypass ports: MEM2WBK_POP_SW in 1; BP_MEM2WBK_EMPTY_SM out 1; MEM_RES_RM out 32; MEM_DEST_RM out 6; MEM_WB_RM out 1; CSR_WENABLE_RM out 1; CSR_RDATA_RM out 32; MULT_INST_RM out 1; EXCEPTION_SM out 1.

Function
REQ-007 SHALL hold a one-entry output slot (valid bit + res, dest, wb, csr_wenable, csr_rdata, mult_inst); all *_RM outputs SHALL drive slot contents, BP_MEM2WBK_EMPTY_SM = !valid.
REQ-008 SHALL drive MEM_DEST_RM = 0 and MEM_WB_RM = 0 while slot invalid.
REQ-009 "head" = !EXE2MEM_EMPTY_SE; "memop" = head & (MEM_LOAD_RE | MEM_STORE_RE) & !EXCEPTION_RE; "slot_free" = !valid | MEM2WBK_POP_SW.
REQ-010 FSM states SHALL be IDLE and ACCESS only.
REQ-011 IDLE, head & !memop & slot_free: SHALL assert EXE2MEM_POP_SM and write slot same cycle (1-cycle latency); res = RES_RE.
REQ-012 IDLE, memop & slot_free: SHALL register DMEM_ADR_SM = RES_RE, DMEM_WE_SM = MEM_STORE_RE, BE, WDATA; set DMEM_REQ_SM = 1; go ACCESS; no pop.
REQ-013 ACCESS: DMEM_REQ_SM and all DMEM_* outputs SHALL stay stable until DMEM_ACK_SM = 1.
REQ-014 ACCESS & DMEM_ACK_SM: SHALL pop head, write slot (load: formatted DMEM_RDATA_SM; store: RES_RE, wb forced 0), clear DMEM_REQ_SM next cycle, return IDLE.
REQ-015 Slot SHALL NOT be written by anything else during ACCESS, so slot is always free at ACK; minimum memop latency 2 cycles.
REQ-016 Slot valid SHALL clear on MEM2WBK_POP_SW with no write; simultaneous pop+write SHALL leave slot valid with the new entry.
REQ-017 Byte enables: word -> 1111; half -> 0011 << adr[1:0]; byte -> 0001 << adr[1:0]; WDATA = MEM_DATA_RE << 8*adr[1:0].
REQ-018 Load result: shift RDATA right by 8*adr[1:0], keep 8/16/32 bits per size, sign-extend if MEM_SIGN_EXTEND_RE else zero-extend.
REQ-019 Head with EXCEPTION_RE: SHALL issue no memory request, EXCEPTION_SM = 1 combinationally, pop when slot_free, write slot with wb = 0, csr_wenable = 0.
REQ-020 EXCEPTION_SM SHALL be 0 whenever head absent or EXCEPTION_RE = 0.
REQ-021 Misaligned addresses are flagged upstream; block SHALL NOT check alignment.

Reset
REQ-022 reset_n = 0 at rising edge SHALL force: state IDLE, DMEM_REQ_SM 0, DMEM_WE_SM 0, DMEM_BE_SM 0, DMEM_ADR_SM 0, DMEM_WDATA_SM 0, slot invalid, slot fields 0.
REQ-023 Reset in ACCESS SHALL abandon the transaction; DMEM_ACK_SM during/after reset with state IDLE SHALL be ignored; no pop.
REQ-024 During reset EXE2MEM_POP_SM SHALL be 0.

Verification
REQ-025 ALU op RES_RE=0x00001234, DEST_RE=5, WB_RE=1, slot empty -> POP same cycle; next cycle MEM_RES_RM=0x00001234, MEM_DEST_RM=5, BP_MEM2WBK_EMPTY_SM=0.
REQ-026 LB signed, RES_RE=0x00001003, ACK 3 cycles after REQ with RDATA=0x80112233 -> BE=1000, MEM_RES_RM=0xFFFFFF80; same with sign-extend 0 -> 0x00000080.
REQ-027 SH RES_RE=0x00002002, MEM_DATA_RE=0x0000ABCD -> DMEM_WE_SM=1, BE=1100, WDATA=0xABCD0000, ADR=0x00002002 held until ACK; slot MEM_WB_RM=0.
REQ-028 Slot full, MEM2WBK_POP_SW=0, ALU head -> POP=0, REQ=0; raising MEM2WBK_POP_SW -> pop and slot write same cycle, slot stays valid.
REQ-029 Head MEM_LOAD_RE=1, EXCEPTION_RE=1 -> DMEM_REQ_SM never asserts, EXCEPTION_SM=1, entry popped, MEM_WB_RM=0.
REQ-030 reset_n=0 for one cycle in ACCESS, then ACK=1 -> REQ=0 after reset, no pop, BP_MEM2WBK_EMPTY_SM=1.
